// File: rtl/benes_route_pkg.sv
// Shared types and switch-index helpers for the Benes route generator and the crossbar bench.
package benes_route_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, WALK, UPDATE, CENTER, DONE} route_state_e;

  // Remove bit `pos` from `value`, closing the gap.
  function automatic int unsigned del_bit(int unsigned value, int unsigned pos);
    int unsigned lo_mask;
    lo_mask = (32'd1 << pos) - 32'd1;
    return ((value >> (pos + 32'd1)) << pos) | (value & lo_mask);
  endfunction

  // Inverse of del_bit: open a zero at bit `pos`.
  function automatic int unsigned ins_bit(int unsigned value, int unsigned pos);
    int unsigned lo_mask;
    lo_mask = (32'd1 << pos) - 32'd1;
    return ((value & ~lo_mask) << 1) | (value & lo_mask);
  endfunction

  function automatic int unsigned ctrl_idx(int unsigned stage, int unsigned line,
                                           int unsigned size = 32);
    int unsigned tagw;
    int unsigned dlog;
    tagw = $clog2(size);
    dlog = (stage < tagw) ? stage : (2 * tagw - 2 - stage);
    return stage * (size / 2) + del_bit(line, dlog);
  endfunction

endpackage

// File: rtl/lowest_unset_pe.sv
// Priority encoder: lowest flag that is neither set nor masked.
module lowest_unset_pe #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] flags_i,
  input  logic [Width-1:0] mask_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  logic [Width-1:0] unset;

  always_comb begin
    unset = ~(flags_i | mask_i);
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (unset[i] && !any_o) begin
        idx_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/benes_route_gen.sv
// Sequential looping-algorithm router: one Benes level per WALK/UPDATE pass, then the centre
// stage, producing the control word for benes_xbar.
module benes_route_gen
  import benes_route_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [SIZE*$clog2(SIZE)-1:0]           req_perm,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [(2*$clog2(SIZE)-1)*(SIZE/2)-1:0] control_bit,
  output logic                                   resp_err
);

  localparam int TAGWIDTH = $clog2(SIZE);
  localparam int STAGES   = 2 * TAGWIDTH - 1;
  localparam int HALF     = SIZE / 2;
  localparam int NCTRL    = STAGES * HALF;
  localparam int HW       = TAGWIDTH - 1;
  localparam int LW       = $clog2(TAGWIDTH);
  localparam int CIW      = $clog2(NCTRL);

  route_state_e state_q, state_d;

  logic [SIZE-1:0][TAGWIDTH-1:0] perm_vec;
  logic [TAGWIDTH-1:0] d_q [SIZE];
  logic [TAGWIDTH-1:0] dinv_q [SIZE];
  logic [TAGWIDTH-1:0] d_nx [SIZE];
  logic [TAGWIDTH-1:0] dinv_nx [SIZE];
  logic [NCTRL-1:0]    ctrl_q;
  logic                err_q;
  logic [LW-1:0]       lvl_q;
  logic [HW-1:0]       cur_q, cnt_q;
  logic                e_q;
  logic [HALF-1:0]     vis_q;

  logic [TAGWIDTH-1:0] m, a, u, o, j, ip, op;
  logic [HW-1:0]       jsw, pe_idx, cur_nx;
  logic [HALF-1:0]     cur_oh;
  logic                pe_any, e_nx, perm_ok;
  logic [SIZE-1:0]     seen;
  logic [CIW-1:0]      ent_idx, ext_idx;

  assign perm_vec = req_perm;
  assign m        = TAGWIDTH'(1) << lvl_q;

  lowest_unset_pe #(
    .Width(HALF),
    .IdxW (HW)
  ) u_pe (
    .flags_i(vis_q),
    .mask_i (cur_oh),
    .idx_o  (pe_idx),
    .any_o  (pe_any)
  );

  // One loop step: the cursor's side-0 line fixes an exit switch, whose partner line pulls the
  // next entry switch into the loop.
  always_comb begin
    a       = TAGWIDTH'(ins_bit(32'(cur_q), 32'(lvl_q)));
    u       = e_q ? (a | m) : a;
    o       = d_q[u];
    j       = dinv_q[o ^ m];
    jsw     = HW'(del_bit(32'(j), 32'(lvl_q)));
    cur_oh  = HALF'(1) << cur_q;
    ent_idx = CIW'(ctrl_idx(32'(lvl_q), 32'(a), SIZE));
    ext_idx = CIW'(ctrl_idx(STAGES - 1 - 32'(lvl_q), 32'(o), SIZE));
    if (!vis_q[jsw] && (jsw != cur_q)) begin
      cur_nx = jsw;
      e_nx   = ~j[lvl_q];
    end else begin
      cur_nx = pe_any ? pe_idx : '0;
      e_nx   = 1'b0;
    end
  end

  always_comb begin
    seen = '0;
    for (int unsigned i = 0; i < SIZE; i++) seen[d_q[TAGWIDTH'(i)]] = 1'b1;
    perm_ok = &seen;
  end

  // Peel off the level just walked: the inner subnet maps post-entry lines to pre-exit lines.
  always_comb begin
    d_nx    = d_q;
    dinv_nx = dinv_q;
    ip      = '0;
    op      = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      ip = TAGWIDTH'(i);
      if (ctrl_q[CIW'(ctrl_idx(32'(lvl_q), i, SIZE))]) ip = ip ^ m;
      op = d_q[TAGWIDTH'(i)];
      if (ctrl_q[CIW'(ctrl_idx(STAGES - 1 - 32'(lvl_q), 32'(op), SIZE))]) op = op ^ m;
      d_nx[ip]    = op;
      dinv_nx[op] = ip;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = CHECK;
      CHECK:   state_d = perm_ok ? WALK : DONE;
      WALK:    if (cnt_q == HW'(HALF - 1)) state_d = UPDATE;
      UPDATE:  state_d = (32'(lvl_q) == 32'(TAGWIDTH - 2)) ? CENTER : WALK;
      CENTER:  state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      lvl_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      vis_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            for (int unsigned i = 0; i < SIZE; i++) d_q[i] <= perm_vec[TAGWIDTH'(i)];
            ctrl_q <= '0;
            err_q  <= 1'b0;
          end
        end
        CHECK: begin
          if (!perm_ok) begin
            err_q <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < SIZE; i++) dinv_q[d_q[TAGWIDTH'(i)]] <= TAGWIDTH'(i);
            lvl_q <= '0;
            vis_q <= '0;
            cur_q <= '0;
            e_q   <= 1'b0;
            cnt_q <= '0;
          end
        end
        WALK: begin
          ctrl_q[ent_idx] <= e_q;
          ctrl_q[ext_idx] <= o[lvl_q];
          vis_q           <= vis_q | cur_oh;
          cur_q           <= cur_nx;
          e_q             <= e_nx;
          cnt_q           <= cnt_q + 1'b1;
        end
        UPDATE: begin
          d_q    <= d_nx;
          dinv_q <= dinv_nx;
          lvl_q  <= lvl_q + 1'b1;
          vis_q  <= '0;
          cur_q  <= '0;
          e_q    <= 1'b0;
          cnt_q  <= '0;
        end
        CENTER: begin
          for (int unsigned k = 0; k < HALF; k++) begin
            ctrl_q[CIW'(ctrl_idx(TAGWIDTH - 1, k, SIZE))] <= (d_q[TAGWIDTH'(k)] != TAGWIDTH'(k));
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign control_bit = ctrl_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_benes_route_gen.sv
// Bench for benes_route_gen: a cycle-level handshake/latency model plus a behavioural Benes
// network that checks the produced control word actually routes the permutation.
module tb_benes_route_gen;

  localparam int SIZE   = 32;
  localparam int TW     = $clog2(SIZE);
  localparam int STAGES = 2 * TW - 1;
  localparam int HALF   = SIZE / 2;
  localparam int NCTRL  = STAGES * HALF;
  localparam int LAT_OK = 2 + (TW - 1) * (HALF + 1);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req_valid = 1'b0;
  logic              resp_ready = 1'b0;
  logic [SIZE*TW-1:0] req_perm = '0;
  logic              req_ready, resp_valid, resp_err;
  logic [NCTRL-1:0]  control_bit;

  int n_checks = 0;
  int n_errors = 0;

  benes_route_gen #(.SIZE(SIZE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_perm   (req_perm),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .control_bit(control_bit),
    .resp_err   (resp_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [NCTRL-1:0] act, input logic [NCTRL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Push data through the network stage by stage; count outputs not carrying their input.
  function automatic int route_errors(input logic [NCTRL-1:0] c, input int unsigned p [SIZE]);
    int unsigned data [SIZE];
    int unsigned d, k, tmp;
    int errs;
    for (int i = 0; i < SIZE; i++) data[i] = i;
    for (int s = 0; s < STAGES; s++) begin
      d = (s < TW) ? (1 << s) : (1 << (STAGES - 1 - s));
      k = 0;
      for (int unsigned ln = 0; ln < SIZE; ln++) begin
        if ((ln & d) == 0) begin
          if (c[s * HALF + k]) begin
            tmp = data[ln]; data[ln] = data[ln + d]; data[ln + d] = tmp;
          end
          k++;
        end
      end
    end
    errs = 0;
    for (int i = 0; i < SIZE; i++) if (data[p[i]] != i) errs++;
    return errs;
  endfunction

  // Handshake/latency model, advanced on the same edges the DUT sees.
  int          m_phase = 0;  // 0 idle, 1 busy, 2 result held
  int          m_left = 0;
  bit          m_err = 1'b0;
  bit          m_fresh = 1'b1;
  int unsigned m_perm [SIZE];
  int unsigned m_cnt [SIZE];

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0;
      m_fresh = 1'b1;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
          for (int i = 0; i < SIZE; i++) begin
            m_perm[i] = req_perm[i*TW +: TW];
            m_cnt[m_perm[i]]++;
          end
          m_err = 1'b0;
          for (int i = 0; i < SIZE; i++) if (m_cnt[i] != 1) m_err = 1'b1;
          m_left  = m_err ? 1 : LAT_OK;
          m_phase = 1;
          m_fresh = 1'b0;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  int               prev_phase = 0;
  logic [NCTRL-1:0] snap_ctrl;
  logic             snap_err;

  always @(negedge CLK) begin
    chk("req_ready", NCTRL'(req_ready), NCTRL'(m_phase == 0));
    chk("resp_valid", NCTRL'(resp_valid), NCTRL'(m_phase == 2));
    if (m_phase == 0 && m_fresh) begin
      chk("idle_ctrl_zero", control_bit, '0);
      chk("idle_err_zero", NCTRL'(resp_err), '0);
    end
    if (m_phase == 2) begin
      chk("resp_err", NCTRL'(resp_err), NCTRL'(m_err));
      if (m_err) chk("err_ctrl_zero", control_bit, '0);
      else chk("route_mismatches", NCTRL'(route_errors(control_bit, m_perm)), '0);
      if (prev_phase != 2) begin
        snap_ctrl = control_bit;
        snap_err  = resp_err;
      end else begin
        chk("hold_ctrl", control_bit, snap_ctrl);
        chk("hold_err", NCTRL'(resp_err), NCTRL'(snap_err));
      end
    end
    prev_phase = m_phase;
  end

  task automatic run_req(input int unsigned p [SIZE], input int hold,
                         output logic [NCTRL-1:0] c, output logic e, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge CLK); n++; end
    for (int i = 0; i < SIZE; i++) req_perm[i*TW +: TW] = TW'(p[i]);
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(negedge CLK); lat++; end
    if (!resp_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_timeout: got no resp_valid want one within 200 cycles");
    end
    c = control_bit;
    e = resp_err;
    repeat (hold) @(negedge CLK);
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
  endtask

  task automatic shuffle(output int unsigned p [SIZE]);
    int unsigned tmp;
    int unsigned r;
    for (int i = 0; i < SIZE; i++) p[i] = i;
    for (int i = SIZE - 1; i > 0; i--) begin
      r = $urandom_range(i, 0);
      tmp = p[i]; p[i] = p[r]; p[r] = tmp;
    end
  endtask

  initial begin
    int unsigned      p [SIZE];
    logic [NCTRL-1:0] c, exp_x;
    logic             e;
    int               lat;
    int unsigned      x, y;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_req_ready", NCTRL'(req_ready), NCTRL'(1));
    chk("rst_resp_valid", NCTRL'(resp_valid), '0);
    chk("rst_ctrl", control_bit, '0);

    for (int i = 0; i < SIZE; i++) p[i] = i;
    run_req(p, 0, c, e, lat);
    chk("ident_latency", NCTRL'(lat), NCTRL'(70));
    chk("ident_ctrl", c, '0);
    chk("ident_err", NCTRL'(e), '0);

    // Only last-stage adjacent swaps; held for 20 cycles before release.
    for (int i = 0; i < SIZE; i++) p[i] = i ^ 1;
    exp_x = NCTRL'(16'hFFFF) << 128;
    run_req(p, 20, c, e, lat);
    chk("xor1_ctrl", c, exp_x);
    chk("xor1_err", NCTRL'(e), '0);
    chk("xor1_latency", NCTRL'(lat), NCTRL'(70));

    for (int i = 0; i < SIZE; i++) p[i] = i;
    p[3] = 5;
    p[7] = 5;
    run_req(p, 2, c, e, lat);
    chk("dup_latency", NCTRL'(lat), NCTRL'(1));
    chk("dup_err", NCTRL'(e), NCTRL'(1));
    chk("dup_ctrl", c, '0);

    // Abort mid-walk, then a clean identity request.
    shuffle(p);
    for (int i = 0; i < SIZE; i++) req_perm[i*TW +: TW] = TW'(p[i]);
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (29) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_req_ready", NCTRL'(req_ready), NCTRL'(1));
    chk("abort_resp_valid", NCTRL'(resp_valid), '0);
    chk("abort_ctrl", control_bit, '0);
    for (int i = 0; i < SIZE; i++) p[i] = i;
    run_req(p, 0, c, e, lat);
    chk("post_abort_latency", NCTRL'(lat), NCTRL'(70));
    chk("post_abort_ctrl", c, '0);

    for (int t = 0; t < 500; t++) begin
      shuffle(p);
      if ($urandom_range(9, 0) == 0) begin
        x = $urandom_range(SIZE - 1, 0);
        y = (x + $urandom_range(SIZE - 1, 1)) % SIZE;
        p[x] = p[y];
      end
      run_req(p, $urandom_range(3, 0), c, e, lat);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
